uart_echo_fifo: RTL and testbench
=================================

# uart_echo_fifo

Parametrised UART echo buffer between `uart_rx` and `uart_tx2`: received bytes go into a circular RAM FIFO and are replayed to the transmitter under a `tx_dv`/`tx_done` handshake. Everything is in a single `ICE_CLK` domain, with no logic clocked off `rx_dv`. Compared with the previous mirror it adds:
- proper wrap-around pointers;
- full/empty and occupancy status;
- a sticky overflow flag;
- an optional line-buffered mode that holds echo until a terminator byte arrives.

## Interface
Parameters:
- `DATA_W`, 8, byte width.
- `DEPTH_LOG2`, 9, FIFO depth = 2^DEPTH_LOG2 entries.
- `LINE_TERM`, 8'h0D, terminator byte for line mode.

Ports:
- `ICE_CLK` in 1: sole clock, all state on its rising edge.
- `RST_N` in 1: reset, asynchronous assert, active-low.
- `rx_dv` in 1: one-cycle strobe, byte valid, synchronous to `ICE_CLK`.
- `rx_byte` in DATA_W: received byte, sampled when `rx_dv`=1.
- `tx_done` in 1: transmitter idle, high when `uart_tx2` can accept a byte.
- `ovf_clr` in 1: clears `overflow`.
- `tx_dv` out 1: one-cycle send strobe.
- `tx_byte` out DATA_W: byte to send; stable from `tx_dv` until the next `tx_dv`.
- `count` out DEPTH_LOG2+1: stored bytes, 0..2^DEPTH_LOG2.
- `empty` out 1: `count`==0.
- `full` out 1: `count`==2^DEPTH_LOG2.
- `overflow` out 1: sticky, a byte was dropped.

## Operation
- Pointers `wr_ptr` and `rd_ptr` are DEPTH_LOG2+1 bits wide, with the extra wrap bit.
  - `count` = `wr_ptr` − `rd_ptr` (mod 2^(DEPTH_LOG2+1)).
  - RAM is addressed with the low DEPTH_LOG2 bits.
- Write path:
  - `rx_dv`=1 and not `full`: write `rx_byte` at `wr_ptr`, then `wr_ptr`++.
  - `rx_dv`=1 and `full`: drop the byte; `wr_ptr` is unchanged; `overflow` is set.
- `overflow` clears only on `ovf_clr`=1. If set and clear coincide, set wins.
- Send FSM `IDLE → LOAD → SEND → WAIT_START → WAIT_DONE → IDLE`:
  - `IDLE`: go to `LOAD` when a byte is eligible and `tx_done`=1.
  - `LOAD`: present `rd_ptr` to the RAM (read latency 1).
  - `SEND`: register RAM output into `tx_byte`, pulse `tx_dv` for 1 cycle, `rd_ptr`++.
  - `WAIT_START`: wait for `tx_done`=0.
  - `WAIT_DONE`: wait for `tx_done`=1, then go to `IDLE`.
- Eligible = `rd_ptr` ≠ `commit_ptr`.
  - Immediate mode: `commit_ptr` ≡ `wr_ptr`.
- Simultaneous write and read in the same cycle:
  - Both pointers update.
  - `count` is unchanged.
  - Addresses never collide, because a read only targets already-written slots.
- Reset values:
  - FSM `IDLE`.
  - Both pointers 0, `commit_ptr` 0.
  - `tx_dv`=0, `tx_byte`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0.
  - RAM contents are not reset.
- Reset asserted mid-transfer discards all FIFO contents. No `tx_dv` is issued until the FSM re-enters `IDLE` with an eligible byte.

## Timing
- A byte whose `rx_dv` is sampled at edge 0 into an empty FIFO, with `tx_done`=1:
  - `count`=1 and `empty`=0 after edge 0.
  - FSM is in `LOAD` after edge 1.
  - `tx_dv`=1 and `tx_byte` valid during the cycle after edge 2.
- Back-to-back bytes are gated by `tx_done`. `tx_dv` never asserts while `tx_done`=0.
- Status outputs are registered and consistent with the pointers after each edge.

## Configuration
- Macro `UART_ECHO_LINE_MODE_EN`.
- Defined: line mode.
  - `commit_ptr` advances to `wr_ptr`+1 when a stored byte equals `LINE_TERM`.
  - `commit_ptr` is also forced to `wr_ptr` when `full`, to prevent deadlock.
  - Bytes after the last terminator are held.
- Undefined: immediate echo. `commit_ptr` logic is absent and eligibility is `!empty`.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `echo_state_t`.
  - Default terminator constant `UART_CR`.
- Sub-module `echo_ram`: simple dual-port RAM with synchronous read, 1-cycle latency, inferred block RAM, parameterised by `DATA_W` and `DEPTH_LOG2`.

## Test plan
1. **Immediate echo.** Send 0x41, 0x42, 0x43 with a `uart_tx2` model.
   - `tx_byte` sequence is 0x41, 0x42, 0x43 in order.
   - First `tx_dv` occurs 2 cycles after the first `rx_dv`.
   - `count` returns to 0.
2. **Fill and overflow.** With `DEPTH_LOG2`=2 and `tx_done` held 0, send 5 bytes.
   - `full`=1 after byte 4.
   - Byte 5 is dropped and `overflow`=1.
   - After releasing `tx_done`, exactly bytes 1–4 are echoed.
   - `ovf_clr` then clears `overflow`.
3. **Pointer wrap.** With `DEPTH_LOG2`=2, stream 20 bytes (0x00–0x13) at transmitter pace.
   - All 20 are echoed in order.
   - `count` never exceeds 4.
4. **Simultaneous read and write.** `rx_dv` lands on the same edge as the `SEND` pointer increment.
   - `count` holds its value.
   - Data order is preserved.
5. **Reset mid-transfer.** Assert `RST_N`=0 while in `WAIT_DONE` with 3 bytes queued.
   - All outputs take reset values asynchronously.
   - No `tx_dv` until new input arrives.
6. **Line mode** (`UART_ECHO_LINE_MODE_EN`). Send "hi" with no terminator.
   - No `tx_dv`.
   - After 0x0D arrives, 0x68, 0x69, 0x0D are echoed.
   - With `DEPTH_LOG2`=2 and no terminator, `full` forces the 4 stored bytes to be released.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo path: send FSM states and the default line terminator.
package uart_pkg;

    localparam int unsigned ECHO_STATE_W = 3;

    typedef enum logic [ECHO_STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_SEND       = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_WAIT_DONE  = 3'd4
    } echo_state_t;

    localparam logic [7:0] UART_CR = 8'h0D;

endpackage

// File: rtl/echo_ram.sv
// Simple dual-port RAM, synchronous read with one cycle of latency; maps onto a block RAM.
module echo_ram #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// UART echo buffer: rx bytes land in a circular RAM FIFO and are replayed under the tx_dv/tx_done handshake.
// Define UART_ECHO_LINE_MODE_EN to hold echo until a LINE_TERM byte (or a full FIFO) releases it.
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       DEPTH_LOG2 = 9,
    parameter logic [DATA_W-1:0] LINE_TERM  = DATA_W'(UART_CR)
) (
    input  logic                  ICE_CLK,
    input  logic                  RST_N,
    input  logic                  rx_dv,
    input  logic [DATA_W-1:0]     rx_byte,
    input  logic                  tx_done,
    input  logic                  ovf_clr,
    output logic                  tx_dv,
    output logic [DATA_W-1:0]     tx_byte,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
);

    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    echo_state_t       state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d, rd_ptr_d, count_d;
    logic              wr_en_c, rd_inc_c, ram_re_c, eligible_c;
    logic [DATA_W-1:0] ram_rdata;

    assign wr_en_c  = rx_dv & ~full;
    assign wr_ptr_d = wr_ptr_q + PTR_W'(wr_en_c);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(rd_inc_c);
    assign count_d  = wr_ptr_d - rd_ptr_d;

`ifdef UART_ECHO_LINE_MODE_EN
    logic [PTR_W-1:0] commit_q;

    // Release through the terminator; a full FIFO releases everything so the sender can never stall.
    always_ff @(posedge ICE_CLK or negedge RST_N) begin
        if (!RST_N) begin
            commit_q <= '0;
        end else if (full) begin
            commit_q <= wr_ptr_q;
        end else if (wr_en_c && (rx_byte == LINE_TERM)) begin
            commit_q <= wr_ptr_q + PTR_W'(1);
        end
    end

    assign eligible_c = (rd_ptr_q != commit_q);
`else
    logic [DATA_W-1:0] unused_line_term;

    assign unused_line_term = LINE_TERM;
    assign eligible_c       = ~empty;
`endif

    echo_ram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (ICE_CLK),
        .we    (wr_en_c),
        .waddr (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata (rx_byte),
        .re    (ram_re_c),
        .raddr (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rdata (ram_rdata)
    );

    // Pointers and status, all registered from the next-pointer values.
    always_ff @(posedge ICE_CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count    <= count_d;
            empty    <= (count_d == '0);
            full     <= (count_d == DEPTH_CNT);
            overflow <= (rx_dv & full) | (overflow & ~ovf_clr);
        end
    end

    always_ff @(posedge ICE_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The read issued on the IDLE->LOAD edge is held through LOAD and captured into tx_byte.
    always_comb begin
        state_d  = state_q;
        ram_re_c = 1'b0;
        rd_inc_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ram_re_c = 1'b1;
                if (eligible_c && tx_done) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                rd_inc_c = 1'b1;
                state_d  = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (!tx_done) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ICE_CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_dv   <= 1'b0;
            tx_byte <= '0;
        end else begin
            tx_dv <= (state_q == ST_LOAD);
            if (state_q == ST_LOAD) begin
                tx_byte <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo (DEPTH_LOG2=2) with a uart_tx2 handshake model.
module tb_uart_echo_fifo;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned DEPTH_LOG2 = 2;
    localparam int          TX_CYC     = 6;

    logic                ICE_CLK   = 1'b0;
    logic                RST_N     = 1'b0;
    logic                rx_dv     = 1'b0;
    logic [DATA_W-1:0]   rx_byte   = '0;
    logic                tx_done   = 1'b1;
    logic                ovf_clr   = 1'b0;
    logic                tx_dv;
    logic [DATA_W-1:0]   tx_byte;
    logic [DEPTH_LOG2:0] count;
    logic                empty;
    logic                full;
    logic                overflow;

    int   tests     = 0;
    int   failed    = 0;
    int   busy      = 0;
    int   max_count = 0;
    logic hold_busy = 1'b0;

    logic [7:0] cap[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] rx;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[23];

    uart_echo_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .LINE_TERM  (8'h0D)
    ) dut (
        .ICE_CLK  (ICE_CLK),
        .RST_N    (RST_N),
        .rx_dv    (rx_dv),
        .rx_byte  (rx_byte),
        .tx_done  (tx_done),
        .ovf_clr  (ovf_clr),
        .tx_dv    (tx_dv),
        .tx_byte  (tx_byte),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    always #5 ICE_CLK = ~ICE_CLK;

    // uart_tx2 model: accepts a byte on tx_dv, stays busy TX_CYC cycles; hold_busy keeps it busy.
    always @(negedge ICE_CLK) begin
        if (tx_dv) begin
            tests++;
            if (!tx_done) begin
                failed++;
                $display("FAIL tx_dv_while_busy: tx_done=%0b required 1", tx_done);
            end
            cap.push_back(tx_byte);
            busy = TX_CYC;
        end else if (busy > 0) begin
            busy--;
        end
        tx_done = (busy == 0) && !hold_busy;
    end

    always @(negedge ICE_CLK) begin
        if (int'(count) > max_count) max_count = int'(count);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        failed++;
        $display("FAIL %s: timeout, count=%0d", name, count);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge ICE_CLK);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge ICE_CLK);
        rx_dv   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        int quiet = 0;
        while (quiet < 4 && n < 3000) begin
            @(negedge ICE_CLK);
            n++;
            if (empty && tx_done && !tx_dv) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) timeout("drain");
    endtask

    task automatic wait_tx_dv(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 300) begin
            @(negedge ICE_CLK);
            n++;
            if (tx_dv) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_tx_dv");
    endtask

    task automatic wait_not_full();
        int n = 0;
        while (full && n < 500) begin
            @(negedge ICE_CLK);
            n++;
        end
        if (full) timeout("wait_not_full");
    endtask

    task automatic check_cap(input string name);
        check({name, " len"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cap.size()) check($sformatf("%s[%0d]", name, i), cap[i], exp_q[i]);
        end
    endtask

    initial begin
        bit ok;
        logic [DEPTH_LOG2:0] c0;

        vecs[0] = '{rx: 8'h41, exp: 8'h41};
        vecs[1] = '{rx: 8'h42, exp: 8'h42};
        vecs[2] = '{rx: 8'h43, exp: 8'h43};
        for (int i = 0; i < 20; i++) vecs[3 + i] = '{rx: 8'(i), exp: 8'(i)};

        // Reset values
        repeat (3) @(negedge ICE_CLK);
        RST_N = 1'b1;
        @(negedge ICE_CLK);
        check("rst tx_dv",    tx_dv,    0);
        check("rst tx_byte",  tx_byte,  0);
        check("rst count",    count,    0);
        check("rst empty",    empty,    1);
        check("rst full",     full,     0);
        check("rst overflow", overflow, 0);

`ifndef UART_ECHO_LINE_MODE_EN
        // 1. Immediate echo with first-byte latency
        cap.delete();
        rx_dv   = 1'b1;
        rx_byte = vecs[0].rx;
        @(negedge ICE_CLK);
        rx_dv = 1'b0;
        check("t1 count e0", count, 1);
        check("t1 empty e0", empty, 0);
        check("t1 tx_dv e0", tx_dv, 0);
        @(negedge ICE_CLK);
        check("t1 tx_dv e1", tx_dv, 0);
        @(negedge ICE_CLK);
        check("t1 tx_dv e2",   tx_dv,   1);
        check("t1 tx_byte e2", tx_byte, 8'h41);
        for (int i = 1; i < 3; i++) send(vecs[i].rx);
        drain();
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(vecs[i].exp);
        check_cap("t1 echo");
        check("t1 count end", count, 0);

        // 2. Fill and overflow with the transmitter held busy
        cap.delete();
        @(negedge ICE_CLK);
        hold_busy = 1'b1;
        for (int i = 0; i < 4; i++) send(8'hA1 + 8'(i));
        check("t2 full", full, 1);
        check("t2 count4", count, 4);
        check("t2 ovf before", overflow, 0);
        send(8'hA5);
        check("t2 ovf set", overflow, 1);
        check("t2 count hold", count, 4);
        hold_busy = 1'b0;
        drain();
        exp_q = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
        check_cap("t2 echo");
        check("t2 ovf sticky", overflow, 1);
        @(negedge ICE_CLK);
        ovf_clr = 1'b1;
        @(negedge ICE_CLK);
        ovf_clr = 1'b0;
        check("t2 ovf clr", overflow, 0);

        // 3. Pointer wrap at transmitter pace
        cap.delete();
        max_count = 0;
        for (int i = 3; i < 23; i++) begin
            wait_not_full();
            send(vecs[i].rx);
        end
        drain();
        exp_q.delete();
        for (int i = 3; i < 23; i++) exp_q.push_back(vecs[i].exp);
        check_cap("t3 wrap");
        check("t3 max count ok", (max_count <= 4), 1);
        check("t3 no ovf", overflow, 0);

        // 4. Write lands on the SEND pointer increment
        cap.delete();
        @(negedge ICE_CLK);
        hold_busy = 1'b1;
        send(8'h51);
        send(8'h52);
        hold_busy = 1'b0;
        wait_tx_dv(ok);
        if (ok) begin
            c0      = count;
            rx_dv   = 1'b1;
            rx_byte = 8'h53;
            @(negedge ICE_CLK);
            rx_dv = 1'b0;
            check("t4 count held", count, c0);
            check("t4 count val", count, 2);
        end
        drain();
        exp_q = {8'h51, 8'h52, 8'h53};
        check_cap("t4 order");

        // 5. Reset while waiting for tx_done with bytes queued
        cap.delete();
        @(negedge ICE_CLK);
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        hold_busy = 1'b0;
        wait_tx_dv(ok);
        repeat (2) @(negedge ICE_CLK);
        check("t5 count pre", count, 3);
        check("t5 ovf pre", overflow, 1);
        #2 RST_N = 1'b0;
        #1;
        check("t5 rst tx_dv",    tx_dv,    0);
        check("t5 rst tx_byte",  tx_byte,  0);
        check("t5 rst count",    count,    0);
        check("t5 rst empty",    empty,    1);
        check("t5 rst full",     full,     0);
        check("t5 rst overflow", overflow, 0);
        @(negedge ICE_CLK);
        RST_N = 1'b1;
        repeat (30) @(negedge ICE_CLK);
        check("t5 no tx after rst", cap.size(), 1);
        send(8'h70);
        drain();
        exp_q = {8'h61, 8'h70};
        check_cap("t5 echo");
`else
        // 6. Line mode: hold until terminator, then release on full
        cap.delete();
        send(8'h68);
        send(8'h69);
        repeat (20) @(negedge ICE_CLK);
        check("t6 held", cap.size(), 0);
        check("t6 count", count, 2);
        send(8'h0D);
        drain();
        exp_q = {8'h68, 8'h69, 8'h0D};
        check_cap("t6 line");
        cap.delete();
        for (int i = 0; i < 4; i++) send(8'h31 + 8'(i));
        drain();
        exp_q = {8'h31, 8'h32, 8'h33, 8'h34};
        check_cap("t6 full release");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
